cpu_core: RTL and testbench
===========================

CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter SCAN_W, default 16: display scan-counter width; digit advances every 2^SCAN_W clocks.
REQ-002 Parameter STEP_W, default 4: step-divider width, used only when CPU_CLKDIV_EN is defined.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 out7  output  7  active-low segments {g,f,e,d,c,b,a} of the currently enabled digit.
REQ-006 en_out  output  8  active-low one-hot digit enable; bit k selects digit k, with digit 0 rightmost.

Function
REQ-007 State: 5-bit PC, four 8-bit registers R0..R3, halted flag, and a 32-entry x 16-bit instruction ROM holding the fixed default program.
REQ-008 Instruction fields: op=[15:12], rd=[11:10], rs=[9:8], imm=[7:0].
REQ-009 Opcodes:
- 0 NOP
- 1 LDI: rd=imm
- 2 ADD: rd=rd+rs
- 3 SUB: rd=rd-rs
- 4 AND
- 5 OR
- 6 XOR: each rd=rd op rs
- 7 ADDI: rd=rd+imm
- 8 JMP: PC=imm[4:0]
- 9 BEQZ: PC=imm[4:0] if rd==0
- A BNEZ: PC=imm[4:0] if rd!=0
- F HALT
- B-E: treated as NOP
REQ-010 Arithmetic is 8-bit modulo 2^8; no flags; wrap-around is silent (0xFF+1=0x00).
REQ-011 Each step fetches ROM[PC] and executes it in the same Clk edge, with no pipeline; non-taken and non-branch instructions set PC=PC+1 mod 32 (31 wraps to 0).
REQ-012 HALT sets halted without changing PC; while halted, PC and registers hold until Reset.
REQ-013 Default program:
- 0: LDI R0,00
- 1: LDI R1,01
- 2: LDI R2,05
- 3: ADD R0,R1
- 4: ADDI R1,01
- 5: ADDI R2,FF
- 6: BNEZ R2,03
- 7: HALT
- 8-31: NOP
REQ-014 Display word is {R3,R2,R1,R0}; digit k shows hex nibble k as a 0-F hex glyph.
REQ-015 The scan counter increments every clock; on wrap, the digit index increments mod 8.
REQ-016 en_out is low only at the bit matching the digit index; out7 is the registered glyph of the displayed value, updated in the same cycle as en_out.
REQ-017 Glyph encodings (active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-018 Display scanning runs independently of halted.

Reset
REQ-019 Reset is sampled on the Clk rising edge, is synchronous and active-high, and overrides any executing instruction.
REQ-020 Reset values: PC=0, R0..R3=0, halted=0, scan counter=0, digit index=0, en_out=0xFE, out7=0x40, step divider=0.
REQ-021 Reset asserted mid-program restarts execution at ROM[0] on the first edge after deassertion.

Configuration
REQ-022 Macro CPU_CLKDIV_EN:
- Defined: an instruction executes only on the clock where a free-running STEP_W-bit divider equals all-ones, i.e. once every 2^STEP_W clocks.
- Undefined: an instruction executes on every clock while not halted.

Structure
REQ-023 Package cpu_pkg holds the opcode constants, instruction field positions, register and PC widths, and the default-program ROM constants.
REQ-024 One sub-module, hex_to_seg7, maps a 4-bit nibble to the 7-bit active-low glyph; cpu_core contains everything else.

Verification
REQ-025 Reset held for 2 edges, then released, macro undefined -> PC=0, all registers 0, en_out=0xFE, out7=0x40.
REQ-026 Default program, macro undefined, 24 edges after reset release -> R0=0x0F, R1=0x06, R2=0x00, R3=0x00, halted=1, PC=7; state holds for a further 50 edges.
REQ-027 SCAN_W=2, after program halt -> en_out cycles FE,FD,FB,F7,EF,DF,BF,7F, each for 4 clocks; out7 sequence 0x0E (F), 0x40 (0), 0x02 (6), 0x40, 0x40, 0x40, 0x40, 0x40.
REQ-028 Reset asserted for 1 edge at edge 10 of the program -> registers clear; the program reruns and reaches the same final values 24 edges after release.
REQ-029 Macro defined with STEP_W=2 -> the program halts after 96 clocks with the same final register values; PC is unchanged across non-step clocks.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for cpu_core: widths, instruction field positions, opcodes
// and the default program held in the instruction ROM.
package cpu_pkg;

  localparam int unsigned IMEM_DEPTH = 32;
  localparam int unsigned PC_W       = $clog2(IMEM_DEPTH);
  localparam int unsigned REG_W      = 8;
  localparam int unsigned NREGS      = 4;
  localparam int unsigned INSTR_W    = 16;

  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 10;
  localparam int unsigned RS_HI  = 9;
  localparam int unsigned RS_LO  = 8;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_JMP  = 4'h8,
    OP_BEQZ = 4'h9,
    OP_BNEZ = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Only the low PROG_LEN ROM words are populated; the rest read as NOP.
  localparam int unsigned PROG_AW  = 3;
  localparam int unsigned PROG_LEN = 1 << PROG_AW;

  localparam logic [INSTR_W-1:0] PROG [PROG_LEN] = '{
    16'h1000,  // LDI  R0,00
    16'h1401,  // LDI  R1,01
    16'h1805,  // LDI  R2,05
    16'h2100,  // ADD  R0,R1
    16'h7401,  // ADDI R1,01
    16'h78FF,  // ADDI R2,FF
    16'hA803,  // BNEZ R2,03
    16'hF000   // HALT
  };

  function automatic logic [INSTR_W-1:0] rom_word(input logic [PC_W-1:0] addr);
    if (addr[PC_W-1:PROG_AW] == '0) return PROG[addr[PROG_AW-1:0]];
    return {OP_NOP, 12'h000};
  endfunction

endpackage

// File: rtl/cpu_hex_to_seg7.sv
// Hex nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 8-bit accumulator-style CPU with a multiplexed 8-digit hex display.
// Optional CPU_CLKDIV_EN: execute one instruction every 2^STEP_W clocks.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned SCAN_W = 16,
  parameter int unsigned STEP_W = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [6:0] out7,
  output logic [7:0] en_out
);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [REG_W-1:0] rf_q [NREGS];
  logic [REG_W-1:0] rf_d [NREGS];
  run_state_e       state_q, state_d;
  logic             halted;
  logic             step_en;

`ifdef CPU_CLKDIV_EN
  logic [STEP_W-1:0] div_q;

  always_ff @(posedge Clk) begin
    if (Reset) div_q <= '0;
    else       div_q <= div_q + 1'b1;
  end

  assign step_en = (div_q == '1);
`else
  // STEP_W only sizes the divider; any legal width steps every clock here.
  assign step_en = (STEP_W != 0);
`endif

  assign halted = (state_q == ST_HALT);

  logic [INSTR_W-1:0]     instr;
  opcode_e                op;
  logic [RD_HI-RD_LO:0]   rd;
  logic [RS_HI-RS_LO:0]   rs;
  logic [IMM_HI-IMM_LO:0] imm;

  always_comb begin
    instr   = rom_word(pc_q);
    op      = opcode_e'(instr[OP_HI:OP_LO]);
    rd      = instr[RD_HI:RD_LO];
    rs      = instr[RS_HI:RS_LO];
    imm     = instr[IMM_HI:IMM_LO];
    pc_d    = pc_q;
    state_d = state_q;
    for (int unsigned i = 0; i < NREGS; i++) rf_d[i] = rf_q[i];

    if (step_en && state_q == ST_RUN) begin
      pc_d = pc_q + 1'b1;
      case (op)
        OP_LDI:  rf_d[rd] = imm;
        OP_ADD:  rf_d[rd] = rf_q[rd] + rf_q[rs];
        OP_SUB:  rf_d[rd] = rf_q[rd] - rf_q[rs];
        OP_AND:  rf_d[rd] = rf_q[rd] & rf_q[rs];
        OP_OR:   rf_d[rd] = rf_q[rd] | rf_q[rs];
        OP_XOR:  rf_d[rd] = rf_q[rd] ^ rf_q[rs];
        OP_ADDI: rf_d[rd] = rf_q[rd] + imm;
        OP_JMP:  pc_d = imm[PC_W-1:0];
        OP_BEQZ: if (rf_q[rd] == '0) pc_d = imm[PC_W-1:0];
        OP_BNEZ: if (rf_q[rd] != '0) pc_d = imm[PC_W-1:0];
        OP_HALT: begin
          pc_d    = pc_q;
          state_d = ST_HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= '0;
      state_q <= ST_RUN;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  logic [SCAN_W-1:0]      scan_q;
  logic [2:0]             digit_q, digit_d;
  logic [4*NREGS*2-1:0]   word;
  logic [3:0]             nib;
  logic [6:0]             glyph;
  logic [7:0]             en_q;
  logic [6:0]             seg_q;

  assign word    = {rf_q[3], rf_q[2], rf_q[1], rf_q[0]};
  assign digit_d = (scan_q == '1) ? digit_q + 1'b1 : digit_q;
  // Enable and glyph both follow the next digit index so they switch together.
  assign nib     = word[{digit_d, 2'b00} +: 4];

  hex_to_seg7 u_seg (
    .nibble_i (nib),
    .seg_o    (glyph)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_q  <= '0;
      digit_q <= '0;
      en_q    <= 8'hFE;
      seg_q   <= 7'h40;
    end else begin
      scan_q  <= scan_q + 1'b1;
      digit_q <= digit_d;
      en_q    <= ~(8'b1 << digit_d);
      seg_q   <= glyph;
    end
  end

  assign en_out = en_q;
  assign out7   = seg_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed, table-driven bench for cpu_core (SCAN_W=2, STEP_W=2).
module tb_cpu_core;

`ifdef CPU_CLKDIV_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  logic       Clk;
  logic       Reset;
  logic [6:0] out7;
  logic [7:0] en_out;

  cpu_core #(.SCAN_W(2), .STEP_W(2)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .out7   (out7),
    .en_out (en_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int sel;
    int exp;
  } state_vec_t;

  typedef struct {
    logic [7:0] en;
    logic [6:0] seg;
  } disp_vec_t;

  int nvec = 0;
  int nerr = 0;

  state_vec_t fin_tbl [6];
  disp_vec_t  disp_tbl [8];

  function automatic int get_state(input int sel);
    case (sel)
      0: return int'(dut.rf_q[0]);
      1: return int'(dut.rf_q[1]);
      2: return int'(dut.rf_q[2]);
      3: return int'(dut.rf_q[3]);
      4: return int'(dut.halted);
      default: return int'(dut.pc_q);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "R0";
      1: return "R1";
      2: return "R2";
      3: return "R3";
      4: return "halted";
      default: return "PC";
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int sel, input int exp);
    chk({tag, ".", sel_name(sel)}, get_state(sel), exp);
  endtask

  task automatic apply_final(input string tag);
    for (int i = 0; i < 6; i++) chk_state(tag, fin_tbl[i].sel, fin_tbl[i].exp);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 5; i++) chk_state(tag, i, 0);
    chk_state(tag, 5, 0);
  endtask

  initial begin
    bit found;
    logic [7:0] prev_en;

    fin_tbl[0] = '{0, 8'h0F};
    fin_tbl[1] = '{1, 8'h06};
    fin_tbl[2] = '{2, 8'h00};
    fin_tbl[3] = '{3, 8'h00};
    fin_tbl[4] = '{4, 1};
    fin_tbl[5] = '{5, 7};

    disp_tbl[0] = '{8'hFE, 7'h0E};
    disp_tbl[1] = '{8'hFD, 7'h40};
    disp_tbl[2] = '{8'hFB, 7'h02};
    disp_tbl[3] = '{8'hF7, 7'h40};
    disp_tbl[4] = '{8'hEF, 7'h40};
    disp_tbl[5] = '{8'hDF, 7'h40};
    disp_tbl[6] = '{8'hBF, 7'h40};
    disp_tbl[7] = '{8'h7F, 7'h40};

    // Reset held for two edges.
    Reset = 1'b1;
    tick(2);
    chk_reset_state("rst");
    chk("rst.en_out", int'(en_out), 8'hFE);
    chk("rst.out7", int'(out7), 7'h40);

    // Run to one step short of HALT, then across the remaining clocks.
    Reset = 1'b0;
    tick(23 * STEP);
    chk_state("pre_halt", 5, 7);
    chk_state("pre_halt", 4, 0);
    for (int k = 0; k < STEP - 1; k++) begin
      tick(1);
      chk_state("nonstep", 5, 7);
      chk_state("nonstep", 4, 0);
    end
    tick(1);
    apply_final("final");

    tick(50);
    apply_final("hold");

    // Align to the start of digit 0, then walk the full scan.
    found   = 1'b0;
    prev_en = en_out;
    for (int k = 0; k < 64 && !found; k++) begin
      tick(1);
      if (en_out == 8'hFE && prev_en == 8'h7F) found = 1'b1;
      prev_en = en_out;
    end
    chk("scan_sync", int'(found), 1);
    if (found) begin
      for (int d = 0; d < 8; d++) begin
        for (int c = 0; c < 4; c++) begin
          if (d != 0 || c != 0) tick(1);
          chk($sformatf("scan.en[%0d.%0d]", d, c), int'(en_out), int'(disp_tbl[d].en));
          chk($sformatf("scan.seg[%0d.%0d]", d, c), int'(out7), int'(disp_tbl[d].seg));
        end
      end
    end

    // Mid-program reset: restart and rerun to the same final state.
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(9 * STEP);
    chk_state("mid", 0, 3);
    chk_state("mid", 1, 3);
    chk_state("mid", 2, 4);
    chk_state("mid", 5, 5);
    Reset = 1'b1;
    tick(1);
    chk_reset_state("mid_rst");
    Reset = 1'b0;
    tick(24 * STEP);
    apply_final("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
